// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline fetch slice.
package arm_pkg;

   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [WORD_W-1:0] PC_INC_DEFAULT   = 32'd4;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_DISCARD
   } fetch_state_e;

   // One fetched word as handed to IF/ID: instruction plus its address + increment.
   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output stage (out + skid) between the fetch sequencer and IF/ID.
module fetch_skid_buf
   import arm_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clear_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t entry_i,
   output logic         outValid_o,
   output fetch_entry_t out_o,
   output logic         skidValid_o
);

   logic         outValid_q, outValid_d;
   logic         skidValid_q, skidValid_d;
   fetch_entry_t out_q, out_d;
   fetch_entry_t skid_q, skid_d;

   // Pop first (skid slides forward), then a push lands in whichever slot is free.
   always_comb begin
      outValid_d  = outValid_q;
      skidValid_d = skidValid_q;
      out_d       = out_q;
      skid_d      = skid_q;
      if (clear_i) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
      end else begin
         if (pop_i) begin
            outValid_d  = skidValid_q;
            out_d       = skid_q;
            skidValid_d = 1'b0;
         end
         if (push_i) begin
            if (!outValid_d) begin
               outValid_d = 1'b1;
               out_d      = entry_i;
            end else begin
               skidValid_d = 1'b1;
               skid_d      = entry_i;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid_q  <= 1'b0;
         skidValid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         outValid_q  <= outValid_d;
         skidValid_q <= skidValid_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
      end
   end

   assign outValid_o  = outValid_q;
   assign out_o       = out_q;
   assign skidValid_o = skidValid_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the memory handshake and
// applies branch redirect / freeze before handing words to IF/ID.
module fetch_controller
   import arm_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branchAddr,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [WORD_W-1:0] Instruction,
   output logic [WORD_W-1:0] PC,
   output logic              flush
);

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] reqAddr_q, reqAddr_d;
   logic              reqActive_q, reqActive_d;

   logic              branchEn;
   logic              memReq;
   logic              completion;
   logic              pushEn;
   logic              popEn;
   logic              outValid;
   logic              skidValid;
   logic [WORD_W-1:0] nextSeq;
   fetch_entry_t      outEntry;
   fetch_entry_t      newEntry;

   assign branchEn   = branch_taken && (state_q != S_BOOT);
   // A started request is never withdrawn; a new one only starts while the skid slot is free.
   assign memReq     = (state_q != S_BOOT) && (reqActive_q || !skidValid);
   assign mem_addr   = reqActive_q ? reqAddr_q : pc_q;
   assign completion = memReq && mem_ready;
   assign nextSeq    = mem_addr + PC_INC;
   assign pushEn     = completion && (state_q == S_RUN) && !branchEn;
   assign popEn      = outValid && !freeze && !branchEn;
   assign newEntry   = '{instr: mem_rdata, pc: nextSeq};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      reqAddr_d   = reqAddr_q;
      reqActive_d = reqActive_q;
      case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (completion) begin
               reqActive_d = 1'b0;
               pc_d        = nextSeq;
            end else if (memReq && !reqActive_q) begin
               reqActive_d = 1'b1;
               reqAddr_d   = pc_q;
            end
            // Redirect overrides the sequential PC; an unfinished request must still drain.
            if (branchEn) begin
               pc_d = branchAddr;
               if (memReq && !mem_ready) state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (mem_ready) begin
               state_d     = S_RUN;
               reqActive_d = 1'b0;
            end
            if (branchEn) pc_d = branchAddr;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_PC;
         reqAddr_q   <= RESET_PC;
         reqActive_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         reqAddr_q   <= reqAddr_d;
         reqActive_q <= reqActive_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (branchEn),
      .push_i      (pushEn),
      .pop_i       (popEn),
      .entry_i     (newEntry),
      .outValid_o  (outValid),
      .out_o       (outEntry),
      .skidValid_o (skidValid)
   );

   assign mem_req     = memReq;
   assign instr_valid = outValid;
   assign Instruction = outEntry.instr;
   assign PC          = outEntry.pc;
   assign flush       = branchEn;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: one task per scenario with inline checks.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branchAddr = '0;
   logic        ready = 1'b0;

   logic        memReq1, memReq2;
   logic [31:0] memAddr1, memAddr2;
   logic [31:0] rdata1, rdata2;
   logic        iValid1, iValid2;
   logic [31:0] instr1, instr2;
   logic [31:0] pc1, pc2;
   logic        flush1, flush2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] instrAt(input logic [31:0] a);
      return a ^ 32'hE1A0_0000;
   endfunction

   assign rdata1 = instrAt(memAddr1);
   assign rdata2 = instrAt(memAddr2);

   fetch_controller dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branchAddr(branchAddr), .mem_req(memReq1), .mem_addr(memAddr1),
      .mem_ready(ready), .mem_rdata(rdata1), .instr_valid(iValid1),
      .Instruction(instr1), .PC(pc1), .flush(flush1)
   );

   fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branchAddr(branchAddr), .mem_req(memReq2), .mem_addr(memAddr2),
      .mem_ready(ready), .mem_rdata(rdata2), .instr_valid(iValid2),
      .Instruction(instr2), .PC(pc2), .flush(flush2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves both DUTs in S_BOOT, just after a rising edge.
   task automatic resetDut();
      rst = 1'b1;
      freeze = 1'b0;
      branch_taken = 1'b0;
      branchAddr = '0;
      ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      resetDut();
      total++; if (memReq1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req got=%b exp=0", memReq1); end
      total++; if (memAddr1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", memAddr1); end
      total++; if (iValid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_instr_valid got=%b exp=0", iValid1); end
      total++; if (instr1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_instruction got=%h exp=0", instr1); end
      total++; if (pc1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0", pc1); end
      total++; if (flush1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush got=%b exp=0", flush1); end
      total++; if (memAddr2 !== 32'hFFFF_FFF8) begin bad++; $display("[TB] FAIL reset_addr_wrapdut got=%h exp=fffffff8", memAddr2); end
   endtask

   task automatic test_streaming();
      resetDut();
      ready = 1'b1;
      tick();
      total++; if (memReq1 !== 1'b1) begin bad++; $display("[TB] FAIL stream_first_req got=%b exp=1", memReq1); end
      total++; if (memAddr1 !== 32'h0) begin bad++; $display("[TB] FAIL stream_first_addr got=%h exp=0", memAddr1); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         total++; if (iValid1 !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid k=%0d got=%b exp=1", k, iValid1); end
         total++; if (pc1 !== 32'(4 * k)) begin bad++; $display("[TB] FAIL stream_pc k=%0d got=%h exp=%h", k, pc1, 32'(4 * k)); end
         total++; if (instr1 !== instrAt(32'(4 * k - 4))) begin bad++; $display("[TB] FAIL stream_instr k=%0d got=%h exp=%h", k, instr1, instrAt(32'(4 * k - 4))); end
      end
      ready = 1'b0;
   endtask

   task automatic test_slow_memory();
      resetDut();
      tick();
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 3; w++) begin
            total++; if (memReq1 !== 1'b1 || memAddr1 !== 32'(4 * k)) begin bad++; $display("[TB] FAIL slow_hold k=%0d w=%0d req=%b addr=%h exp_addr=%h", k, w, memReq1, memAddr1, 32'(4 * k)); end
            if (w == 1) begin
               total++; if (iValid1 !== 1'b0) begin bad++; $display("[TB] FAIL slow_idle k=%0d got=%b exp=0", k, iValid1); end
            end
            tick();
         end
         ready = 1'b1;
         tick();
         ready = 1'b0;
         total++; if (iValid1 !== 1'b1) begin bad++; $display("[TB] FAIL slow_valid k=%0d got=%b exp=1", k, iValid1); end
         total++; if (pc1 !== 32'(4 * k + 4)) begin bad++; $display("[TB] FAIL slow_pc k=%0d got=%h exp=%h", k, pc1, 32'(4 * k + 4)); end
         total++; if (instr1 !== instrAt(32'(4 * k))) begin bad++; $display("[TB] FAIL slow_instr k=%0d got=%h exp=%h", k, instr1, instrAt(32'(4 * k))); end
      end
   endtask

   task automatic test_freeze();
      resetDut();
      ready = 1'b1;
      tick();
      tick();
      total++; if (pc1 !== 32'h4) begin bad++; $display("[TB] FAIL frz_pre_pc got=%h exp=4", pc1); end
      freeze = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (iValid1 !== 1'b1 || pc1 !== 32'h4 || instr1 !== instrAt(32'h0)) begin bad++; $display("[TB] FAIL frz_hold c=%0d valid=%b pc=%h instr=%h exp_pc=4", c, iValid1, pc1, instr1); end
         total++; if (memReq1 !== 1'b0) begin bad++; $display("[TB] FAIL frz_req_drop c=%0d got=%b exp=0", c, memReq1); end
      end
      freeze = 1'b0;
      for (int k = 2; k <= 4; k++) begin
         tick();
         total++; if (iValid1 !== 1'b1 || pc1 !== 32'(4 * k)) begin bad++; $display("[TB] FAIL frz_release k=%0d valid=%b pc=%h exp=%h", k, iValid1, pc1, 32'(4 * k)); end
         total++; if (instr1 !== instrAt(32'(4 * k - 4))) begin bad++; $display("[TB] FAIL frz_release_instr k=%0d got=%h exp=%h", k, instr1, instrAt(32'(4 * k - 4))); end
      end
      ready = 1'b0;
   endtask

   task automatic test_branch_discard();
      resetDut();
      tick();
      tick();
      tick();
      branch_taken = 1'b1;
      branchAddr = 32'h100;
      #1;
      total++; if (flush1 !== 1'b1) begin bad++; $display("[TB] FAIL br_flush got=%b exp=1", flush1); end
      tick();
      branch_taken = 1'b0;
      #1;
      total++; if (memReq1 !== 1'b1 || memAddr1 !== 32'h0) begin bad++; $display("[TB] FAIL br_discard_hold req=%b addr=%h exp_addr=0", memReq1, memAddr1); end
      total++; if (flush1 !== 1'b0) begin bad++; $display("[TB] FAIL br_flush_pulse got=%b exp=0", flush1); end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      total++; if (iValid1 !== 1'b0) begin bad++; $display("[TB] FAIL br_stale_dropped got=%b exp=0", iValid1); end
      total++; if (memReq1 !== 1'b1 || memAddr1 !== 32'h100) begin bad++; $display("[TB] FAIL br_target_addr req=%b addr=%h exp=100", memReq1, memAddr1); end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      total++; if (iValid1 !== 1'b1 || pc1 !== 32'h104) begin bad++; $display("[TB] FAIL br_target_pc valid=%b pc=%h exp=104", iValid1, pc1); end
      total++; if (instr1 !== instrAt(32'h100)) begin bad++; $display("[TB] FAIL br_target_instr got=%h exp=%h", instr1, instrAt(32'h100)); end
   endtask

   task automatic test_branch_freeze();
      resetDut();
      ready = 1'b1;
      tick();
      tick();
      freeze = 1'b1;
      tick();
      total++; if (memReq1 !== 1'b0) begin bad++; $display("[TB] FAIL bf_skid_full got=%b exp=0", memReq1); end
      branch_taken = 1'b1;
      branchAddr = 32'h200;
      #1;
      total++; if (flush1 !== 1'b1) begin bad++; $display("[TB] FAIL bf_flush got=%b exp=1", flush1); end
      tick();
      branch_taken = 1'b0;
      freeze = 1'b0;
      #1;
      total++; if (iValid1 !== 1'b0) begin bad++; $display("[TB] FAIL bf_cleared got=%b exp=0", iValid1); end
      total++; if (memReq1 !== 1'b1 || memAddr1 !== 32'h200) begin bad++; $display("[TB] FAIL bf_resume req=%b addr=%h exp=200", memReq1, memAddr1); end
      tick();
      total++; if (iValid1 !== 1'b1 || pc1 !== 32'h204) begin bad++; $display("[TB] FAIL bf_first valid=%b pc=%h exp=204", iValid1, pc1); end
      tick();
      total++; if (pc1 !== 32'h208) begin bad++; $display("[TB] FAIL bf_second pc=%h exp=208", pc1); end
      ready = 1'b0;
   endtask

   task automatic test_wrap_and_abort();
      resetDut();
      ready = 1'b1;
      tick();
      total++; if (memAddr2 !== 32'hFFFF_FFF8) begin bad++; $display("[TB] FAIL wrap_addr0 got=%h exp=fffffff8", memAddr2); end
      tick();
      total++; if (memAddr2 !== 32'hFFFF_FFFC || pc2 !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_step1 addr=%h pc=%h exp=fffffffc", memAddr2, pc2); end
      tick();
      total++; if (memAddr2 !== 32'h0 || pc2 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_step2 addr=%h pc=%h exp=0", memAddr2, pc2); end
      tick();
      total++; if (pc2 !== 32'h4 || instr2 !== instrAt(32'h0)) begin bad++; $display("[TB] FAIL wrap_step3 pc=%h instr=%h exp_pc=4", pc2, instr2); end
      ready = 1'b0;
      tick();
      total++; if (memReq2 !== 1'b1) begin bad++; $display("[TB] FAIL abort_pending got=%b exp=1", memReq2); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (memReq2 !== 1'b0 || memReq1 !== 1'b0) begin bad++; $display("[TB] FAIL abort_async req_wrap=%b req=%b exp=0", memReq2, memReq1); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      $display("[TB] fetch_controller bench start");
      test_reset();
      test_streaming();
      test_slow_memory();
      test_freeze();
      test_branch_discard();
      test_branch_freeze();
      test_wrap_and_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
